uart_rx: RTL and testbench

- Serial receiver stage that consumes the line driven by the UART transmitter.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous rx pin using an internal bit-period counter; no external baud clock is needed.
- Presents each byte on a held data register with a ready/ack handshake to the downstream consumer, plus framing and overrun status.
- Targets clk <= 12 MHz; default timing is 9600 baud at 12 MHz.

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with an internal bit-period counter.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - serial line, idle high, asynchronous to clk
//   rx_enable  - when low, IDLE ignores rx; a frame already in progress completes
//   dout       - last received byte, held until overwritten
//   dout_ready - high while dout holds an unread byte
//   rd_ack     - one-cycle consumer acknowledge; clears dout_ready and overrun
//   frame_err  - one-cycle pulse when the sampled stop bit is 0
//   overrun    - sticky; a byte completed while dout_ready was still high
//   busy       - high whenever the receiver FSM is not in IDLE
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_enable,
  output logic [7:0] dout,
  output logic       dout_ready,
  input  logic       rd_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            done_q, done_d;
  logic            stop_ok_q, stop_ok_d;
  logic [7:0]      dout_q, dout_d;
  logic            dout_ready_q, dout_ready_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    done_d       = 1'b0;
    stop_ok_d    = stop_ok_q;
    dout_d       = dout_q;
    dout_ready_d = dout_ready_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (rx_enable && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CW'(HALF_BIT - 1)) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
          stop_ok_d = rx_s_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Result of the stop sample is committed one edge later; a completing
    // byte takes priority over a coincident rd_ack.
    if (done_q && stop_ok_q) begin
      dout_d       = shift_q;
      dout_ready_d = 1'b1;
      if (dout_ready_q && !rd_ack) begin
        overrun_d = 1'b1;
      end else if (dout_ready_q && rd_ack) begin
        overrun_d = 1'b0;
      end
    end else if (rd_ack && dout_ready_q) begin
      dout_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
    frame_err_d = done_q && !stop_ok_q;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      stop_ok_q    <= 1'b0;
      dout_q       <= '0;
      dout_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      stop_ok_q    <= stop_ok_d;
      dout_q       <= dout_d;
      dout_ready_q <= dout_ready_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ready = dout_ready_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at CLKS_PER_BIT=104, checked every
// cycle against a frame-level model (expected completion edge and busy
// windows per frame) plus hand-computed literal checks.
module tb_uart_rx;

  localparam int unsigned CPB  = 104;
  localparam int unsigned HB   = 52;
  // Edge offsets from the first edge that samples the start bit low.
  localparam int unsigned DONE = 2 + HB + 9 * CPB + 1;   // 991
  localparam int unsigned IDLE_AT = 2 + HB + 9 * CPB;    // 990

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_enable;
  logic       rd_ack;
  logic [7:0] dout;
  logic       dout_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_enable(rx_enable),
    .dout(dout), .dout_ready(dout_ready), .rd_ack(rd_ack),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;
  int fe_cnt = 0;

  typedef struct {
    int unsigned at;
    logic [7:0]  b;
    bit          ok;
  } ev_t;
  typedef struct {
    int unsigned lo;
    int unsigned hi;
  } iv_t;

  ev_t evq[$];
  iv_t busyq[$];
  int unsigned cyc = 0;
  int unsigned lastc = 0;
  int unsigned last_e0 = 0;

  logic [7:0] m_dout  = 8'h00;
  bit         m_ready = 1'b0;
  bit         m_ferr  = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_hit;
  bit         m_ok;
  logic [7:0] m_b;

  // Frame-level model: each expected frame completes at a known edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      evq.delete();
      busyq.delete();
      m_dout  = 8'h00;
      m_ready = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_hit = 1'b0;
      m_ok  = 1'b0;
      m_b   = 8'h00;
      foreach (evq[i]) begin
        if (evq[i].at == cyc) begin
          m_hit = 1'b1;
          m_ok  = evq[i].ok;
          m_b   = evq[i].b;
        end
      end
      m_ferr = m_hit && !m_ok;
      if (m_hit && m_ok) begin
        if (m_ready) m_ovr = !rd_ack;
        m_dout  = m_b;
        m_ready = 1'b1;
      end else if (rd_ack && m_ready) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
      lastc = cyc;
      cyc   = cyc + 1;
    end
  end

  function automatic bit busy_exp();
    foreach (busyq[i]) begin
      if (busyq[i].lo <= lastc && lastc < busyq[i].hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      vectors++;
      if (dout !== m_dout || dout_ready !== m_ready || frame_err !== m_ferr ||
          overrun !== m_ovr || busy !== busy_exp()) begin
        miscompares++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_%0d: dout=%h/%h ready=%b/%b ferr=%b/%b ovr=%b/%b busy=%b/%b (got/exp)",
                   lastc, dout, m_dout, dout_ready, m_ready, frame_err, m_ferr,
                   overrun, m_ovr, busy, busy_exp());
        end
      end
    end
  end

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'h00);
    chk({tag, "_ready"}, 32'(dout_ready), 32'h0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
    chk({tag, "_ovr"}, 32'(overrun), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the stop bit ends.
  task automatic send_byte(input logic [7:0] b, input bit stop_bit,
                           input bit expect_rx, input int abort_at);
    logic [9:0]  fr;
    int unsigned e0;
    fr = {stop_bit, b, 1'b0};
    e0 = cyc;
    last_e0 = e0;
    if (expect_rx) begin
      evq.push_back('{at: e0 + DONE, b: b, ok: stop_bit});
      busyq.push_back('{lo: e0 + 2, hi: e0 + IDLE_AT});
      // A low stop bit still on the line re-triggers START, which then
      // rejects it as a glitch once the line has gone idle.
      if (!stop_bit) busyq.push_back('{lo: e0 + DONE, hi: e0 + DONE + HB});
    end
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at + 1) begin
        rst = 1'b1;
        #1;
        chk_zero("abort");
        #1;
        rst = 1'b0;
      end
      rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic wait_ready(output int unsigned at);
    at = 0;
    @(negedge clk);
    for (int i = 0; i < 1200; i++) begin
      if (dout_ready === 1'b1) begin
        at = lastc;
        break;
      end
      @(negedge clk);
    end
  endtask

  int unsigned rise_at;
  int          busy_cycles;
  int          fe_before;
  int unsigned g0;

  initial begin
    rst = 1'b1; rx = 1'b1; rx_enable = 1'b1; rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0x41 with latency window and handshake.
    fork
      send_byte(8'h41, 1'b1, 1'b1, 99);
      wait_ready(rise_at);
    join
    chk("latency", 32'((rise_at >= last_e0 + 990) && (rise_at <= last_e0 + 992)), 32'h1);
    chk("t1_dout", 32'(dout), 32'h41);
    chk("t1_ready", 32'(dout_ready), 32'h1);
    chk("t1_ovr", 32'(overrun), 32'h0);
    ack();
    chk("t1_ack", 32'(dout_ready), 32'h0);
    repeat (10) @(negedge clk);

    // 30-cycle glitch: busy for exactly HALF_BIT cycles, nothing else.
    g0 = cyc;
    busyq.push_back('{lo: g0 + 2, hi: g0 + 2 + HB});
    rx = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 90; i++) begin
      if (i == 30) rx = 1'b1;
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    chk("glitch_busy", 32'(busy_cycles), 32'd52);
    chk("glitch_ready", 32'(dout_ready), 32'h0);
    send_byte(8'h5A, 1'b1, 1'b1, 99);
    chk("t2_dout", 32'(dout), 32'h5A);
    ack();
    repeat (10) @(negedge clk);

    // Framing error.
    fe_before = fe_cnt;
    send_byte(8'hC3, 1'b0, 1'b1, 99);
    repeat (20) @(negedge clk);
    chk("ferr_pulses", 32'(fe_cnt - fe_before), 32'd1);
    chk("ferr_ready", 32'(dout_ready), 32'h0);
    chk("ferr_dout", 32'(dout), 32'h5A);

    // Back-to-back without ack.
    send_byte(8'h11, 1'b1, 1'b1, 99);
    send_byte(8'h22, 1'b1, 1'b1, 99);
    repeat (5) @(negedge clk);
    chk("b2b_dout", 32'(dout), 32'h22);
    chk("b2b_ready", 32'(dout_ready), 32'h1);
    chk("b2b_ovr", 32'(overrun), 32'h1);
    ack();
    chk("b2b_ack_ready", 32'(dout_ready), 32'h0);
    chk("b2b_ack_ovr", 32'(overrun), 32'h0);
    repeat (10) @(negedge clk);

    // Reset after 4 data bits of 0xFF, then 0x0F.
    send_byte(8'hFF, 1'b1, 1'b1, 4);
    repeat (20) @(negedge clk);
    chk("post_rst_ready", 32'(dout_ready), 32'h0);
    chk("post_rst_dout", 32'(dout), 32'h00);
    send_byte(8'h0F, 1'b1, 1'b1, 99);
    chk("t5_dout", 32'(dout), 32'h0F);
    chk("t5_ready", 32'(dout_ready), 32'h1);
    ack();
    repeat (10) @(negedge clk);

    // Disabled receiver ignores a frame.
    rx_enable = 1'b0;
    send_byte(8'h55, 1'b1, 1'b0, 99);
    repeat (5) @(negedge clk);
    chk("dis_ready", 32'(dout_ready), 32'h0);
    chk("dis_dout", 32'(dout), 32'h0F);
    rx_enable = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h55, 1'b1, 1'b1, 99);
    chk("en_dout", 32'(dout), 32'h55);
    chk("en_ready", 32'(dout_ready), 32'h1);

    // rd_ack exactly on the completion edge of 0x33 while 0x55 is unread.
    fork
      send_byte(8'h33, 1'b1, 1'b1, 99);
      begin
        @(negedge clk);
        for (int i = 0; i < 1100; i++) begin
          if (cyc == last_e0 + DONE) begin
            ack();
            break;
          end
          @(negedge clk);
        end
      end
    join
    chk("coinc_dout", 32'(dout), 32'h33);
    chk("coinc_ready", 32'(dout_ready), 32'h1);
    chk("coinc_ovr", 32'(overrun), 32'h0);
    ack();
    chk("coinc_ack", 32'(dout_ready), 32'h0);
    ack();
    chk("idle_ack", 32'(dout_ready), 32'h0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
